// File: rtl/uart_tx_scheduler_if.sv
// FIFO read port seen by the UART transmit scheduler.
// master = scheduler side, slave = FIFO side.
interface uart_tx_scheduler_if #(
  parameter int DWIDTH = 8
);
  logic              empty;
  logic [DWIDTH-1:0] rdata;
  logic              rd;

  modport master (
    input  empty,
    input  rdata,
    output rd
  );

  modport slave (
    output empty,
    output rdata,
    input  rd
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Drains the TX FIFO one word per frame and serializes it onto txd.
// Frame: start, data LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_scheduler #(
  parameter int DWIDTH = 8,
  parameter int DIV_W  = 16
) (
  input  logic             clk,
  input  logic             a_resetn,
  input  logic             enable,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  uart_tx_scheduler_if.master fifo,
  output logic             txd,
  output logic             busy,
  output logic             tx_done
);

  localparam int BW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE, GUARD, READ, CAPT,
    START, DATA, PARITY, STOP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DIV_W-1:0]  baud_q;
  logic [DIV_W-1:0]  div_q;
  logic [BW-1:0]     bit_q;
  logic [DWIDTH-1:0] shreg_q;
  logic              par_en_q;
  logic              stop2_q;
  logic              par_bit_q;

  logic             go;
  logic             bit_end;
  logic             data_last;
  logic             stop_last;
  logic [DIV_W-1:0] eff_div;

  assign go        = enable & ~fifo.empty;
  assign bit_end   = (baud_q == div_q - DIV_W'(1));
  assign data_last = (bit_q == BW'(DWIDTH - 1));
  assign stop_last = stop2_q ? (bit_q == BW'(1))
                             : (bit_q == '0);
  // Dividers below 2 would leave no room for a bit period.
  assign eff_div   = (clk_div < DIV_W'(2)) ? DIV_W'(2)
                                           : clk_div;

  always_ff @(posedge clk or negedge a_resetn) begin
    if (!a_resetn) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (go) state_nxt = GUARD;
      GUARD:  state_nxt = go ? READ : IDLE;
      READ:   state_nxt = CAPT;
      CAPT:   state_nxt = START;
      START:  if (bit_end) state_nxt = DATA;
      DATA: begin
        if (bit_end && data_last)
          state_nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_nxt = STOP;
      STOP: begin
        if (bit_end && stop_last)
          state_nxt = go ? GUARD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge a_resetn) begin
    if (!a_resetn) begin
      baud_q    <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      unique case (state)
        CAPT: begin
          shreg_q   <= fifo.rdata;
          div_q     <= eff_div;
          par_en_q  <= parity_en;
          stop2_q   <= stop2;
          par_bit_q <= (^fifo.rdata) ^ parity_odd;
          baud_q    <= '0;
          bit_q     <= '0;
        end
        START, DATA, PARITY, STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (state == DATA) begin
              shreg_q <= shreg_q >> 1;
              bit_q   <= data_last ? '0
                                   : bit_q + BW'(1);
            end else if (state == STOP) begin
              bit_q <= bit_q + BW'(1);
            end
          end else begin
            baud_q <= baud_q + DIV_W'(1);
          end
        end
        default: begin
          baud_q <= '0;
          bit_q  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    txd = 1'b1;
    unique case (1'b1)
      (state == START):  txd = 1'b0;
      (state == DATA):   txd = shreg_q[0];
      (state == PARITY): txd = par_bit_q;
      default:           txd = 1'b1;
    endcase
  end

  assign fifo.rd = (state == READ);
  assign busy    = (state != IDLE);
  assign tx_done = (state == STOP) & bit_end & stop_last;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: FIFO model feeds the scheduler, a monitor
// decodes txd cycle by cycle against the expected frames.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        a_resetn;
  logic        enable;
  logic [15:0] clk_div;
  logic        parity_en;
  logic        parity_odd;
  logic        stop2;
  logic        txd;
  logic        busy;
  logic        tx_done;

  uart_tx_scheduler_if #(.DWIDTH(8)) fifo_if ();

  uart_tx_scheduler #(.DWIDTH(8), .DIV_W(16)) dut (
    .clk        (clk),
    .a_resetn   (a_resetn),
    .enable     (enable),
    .clk_div    (clk_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .fifo       (fifo_if.master),
    .txd        (txd),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         pen;
    bit         podd;
    bit         s2;
  } exp_t;

  exp_t sb[$];
  logic [7:0] fmem[$];
  logic       wr_req = 1'b0;
  logic [7:0] wr_data = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int frames_done = 0;
  bit frame_active = 1'b0;
  int start_cyc, end_cyc, frame_len;
  int last_lat, last_gap;
  int t_ready = 0;
  bit prev_cond = 1'b0;
  int rd_cnt = 0;
  int rd_empty_viol = 0;
  int early_viol = 0;
  int empty_run = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: registered read data, empty flag lags a write by one edge
  always @(posedge clk) begin
    if (fifo_if.rd === 1'b1 && fmem.size() > 0)
      fifo_if.rdata <= fmem.pop_front();
    if (wr_req) fmem.push_back(wr_data);
    fifo_if.empty <= (fmem.size() == 0);
  end

  always @(negedge clk) begin
    bit cond;
    empty_run = (fifo_if.empty === 1'b0) ? empty_run + 1 : 0;
    if (fifo_if.rd === 1'b1) begin
      rd_cnt++;
      if (fifo_if.empty !== 1'b0) rd_empty_viol++;
      if (empty_run < 2) early_viol++;
    end
    cond = (a_resetn === 1'b1) && (busy === 1'b0) &&
           (fifo_if.empty === 1'b0) && (enable === 1'b1);
    if (cond && !prev_cond) t_ready = cyc;
    prev_cond = cond;
  end

  exp_t mexp;
  logic mbits[$];
  int   md;
  bit   mab;

  always begin : monitor
    @(negedge clk);
    if (a_resetn === 1'b1 && txd === 1'b0) begin
      start_cyc = cyc;
      last_lat  = cyc - t_ready;
      if (frames_done > 0) last_gap = cyc - end_cyc - 1;
      frame_active = 1'b1;
      if (sb.size() == 0) begin
        chk("unexpected_frame", 1, 0);
        mexp = '{data: 8'h00, div: 2, pen: 0, podd: 0, s2: 0};
      end else begin
        mexp = sb.pop_front();
      end
      md = (mexp.div < 2) ? 2 : mexp.div;
      mbits.delete();
      mbits.push_back(1'b0);
      for (int i = 0; i < 8; i++) mbits.push_back(mexp.data[i]);
      if (mexp.pen) mbits.push_back((^mexp.data) ^ mexp.podd);
      mbits.push_back(1'b1);
      if (mexp.s2) mbits.push_back(1'b1);
      mab = 1'b0;
      for (int b = 0; b < mbits.size() && !mab; b++) begin
        for (int c = 0; c < md && !mab; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (a_resetn !== 1'b1) begin
            mab = 1'b1;
          end else begin
            chk($sformatf("txd_bit%0d", b), {31'b0, txd},
                {31'b0, mbits[b]});
            chk("tx_done", {31'b0, tx_done},
                ((b == mbits.size() - 1) && (c == md - 1)) ? 1 : 0);
          end
        end
      end
      if (!mab) begin
        end_cyc   = cyc;
        frame_len = cyc - start_cyc + 1;
        frames_done++;
      end
      frame_active = 1'b0;
    end
  end

  task automatic push_word(input logic [7:0] d);
    wr_req  = 1'b1;
    wr_data = d;
    sb.push_back('{data: d, div: int'(clk_div), pen: parity_en,
                   podd: parity_odd, s2: stop2});
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 2000 && frames_done < target; i++)
      @(negedge clk);
    chk("frame_timeout", (frames_done >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_start();
    for (int i = 0; i < 200 && !frame_active; i++)
      @(negedge clk);
    chk("start_timeout", {31'b0, frame_active}, 1);
  endtask

  int rd0;
  int low;

  initial begin
    a_resetn   = 1'b0;
    enable     = 1'b0;
    clk_div    = 16'd4;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop2      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'b0, txd}, 1);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, tx_done}, 0);
    chk("rst_rd", {31'b0, fifo_if.rd}, 0);
    a_resetn = 1'b1;
    @(negedge clk);

    // single word, no parity
    enable = 1'b1;
    push_word(8'hA5);
    wait_frames(1);
    chk("t1_len", frame_len, 40);
    chk("t1_latency", last_lat, 4);
    chk("t1_rd_cnt", rd_cnt, 1);
    chk("t1_fifo", fmem.size(), 0);
    @(negedge clk);

    // parity even, odd, odd with two stop bits
    parity_en = 1'b1;
    push_word(8'hA5);
    wait_frames(2);
    chk("par_even_len", frame_len, 44);
    @(negedge clk);
    parity_odd = 1'b1;
    push_word(8'hA5);
    wait_frames(3);
    chk("par_odd_len", frame_len, 44);
    @(negedge clk);
    stop2 = 1'b1;
    push_word(8'hA5);
    wait_frames(4);
    chk("stop2_len", frame_len, 48);
    @(negedge clk);

    // back-to-back words
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop2      = 1'b0;
    rd0 = rd_cnt;
    push_word(8'h01);
    push_word(8'h80);
    wait_frames(6);
    chk("b2b_gap", last_gap, 3);
    chk("b2b_rd", rd_cnt - rd0, 2);
    chk("b2b_fifo", fmem.size(), 0);
    @(negedge clk);

    // minimum divider and write hazard
    clk_div = 16'd0;
    rd0 = rd_cnt;
    push_word(8'h3C);
    wait_frames(7);
    chk("div0_len", frame_len, 20);
    chk("div0_rd", rd_cnt - rd0, 1);
    chk("div0_latency", last_lat, 4);
    @(negedge clk);

    // enable dropped mid-frame with 3 words queued
    clk_div = 16'd4;
    rd0 = rd_cnt;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    wait_start();
    repeat (12) @(negedge clk);
    enable = 1'b0;
    wait_frames(8);
    repeat (30) @(negedge clk);
    chk("en_fifo_held", fmem.size(), 2);
    chk("en_rd_once", rd_cnt - rd0, 1);
    chk("en_idle", {31'b0, busy}, 0);
    enable = 1'b1;
    wait_frames(10);
    chk("en_resume_fifo", fmem.size(), 0);
    chk("en_resume_rd", rd_cnt - rd0, 3);
    @(negedge clk);

    // reset pulse during DATA
    push_word(8'h5A);
    wait_start();
    repeat (16) @(negedge clk);
    #1 a_resetn = 1'b0;
    #1;
    chk("arst_txd", {31'b0, txd}, 1);
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_rd", {31'b0, fifo_if.rd}, 0);
    @(negedge clk);
    @(negedge clk);
    a_resetn = 1'b1;
    rd0 = rd_cnt;
    low = 0;
    repeat (20) begin
      @(negedge clk);
      if (txd !== 1'b1) low++;
    end
    chk("post_rst_txd", low, 0);
    chk("post_rst_rd", rd_cnt - rd0, 0);
    chk("post_rst_busy", {31'b0, busy}, 0);

    chk("rd_while_empty", rd_empty_viol, 0);
    chk("rd_early", early_viol, 0);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_checks, n_fail);
    $finish;
  end

endmodule
